// File: rtl/hex_keypad_scanner_pkg.sv
// Shared definitions for the hex keypad scanner.
//   KEY_ROWS / KEY_COLS : keypad matrix geometry (4x4)
//   KEY_CODE_W          : width of an emitted key code ({row[1:0], col[1:0]})
//   scan_state_t        : debounce FSM encoding, shared with the IO block and benches
//   sweep_kind_t        : classification of one full four-column sweep
//   sweep_result_t      : sweep classification plus the single-key code (zero unless ONE)
package hex_keypad_scanner_pkg;

  localparam int KEY_ROWS   = 4;
  localparam int KEY_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    CONFIRM   = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } scan_state_t;

  typedef enum logic [1:0] {
    SW_NONE  = 2'd0,
    SW_ONE   = 2'd1,
    SW_MULTI = 2'd2
  } sweep_kind_t;

  typedef struct packed {
    sweep_kind_t             kind;
    logic [KEY_CODE_W-1:0]   code;
  } sweep_result_t;

  // Number of active-low (pressed) rows in one column sample.
  function automatic logic [2:0] count_low(input logic [KEY_ROWS-1:0] rows);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < KEY_ROWS; i++) begin
      if (!rows[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest-numbered active-low row; only meaningful when exactly one is low.
  function automatic logic [1:0] first_low(input logic [KEY_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Key hand-off bus between the keypad scanner (master) and the IO block (slave).
//   KEY_CODE  : code of the accepted key, {row[1:0], col[1:0]}
//   KEY_VALID : KEY_CODE holds a key not yet taken
//   KEY_ACK   : consumer takes the key
//   KEY_DOWN  : debounced key currently held
//   OVERFLOW  : sticky, a press was dropped while a key was pending
// Handshake: a transfer happens on every rising clock edge where KEY_VALID=1 and
// KEY_ACK=1. KEY_VALID rises only when a new key is accepted and, once high, stays high
// with KEY_CODE stable until that transfer edge (unless a new key is loaded on the very
// same edge). KEY_ACK while KEY_VALID=0 has no effect; there is no ready back-pressure on
// the scanner side, so a key accepted while one is still pending is dropped and flagged.
interface hex_keypad_scanner_if;
  import hex_keypad_scanner_pkg::*;

  logic [KEY_CODE_W-1:0] KEY_CODE;
  logic                  KEY_VALID;
  logic                  KEY_ACK;
  logic                  KEY_DOWN;
  logic                  OVERFLOW;

  modport master (
    output KEY_CODE,
    output KEY_VALID,
    output KEY_DOWN,
    output OVERFLOW,
    input  KEY_ACK
  );

  modport slave (
    input  KEY_CODE,
    input  KEY_VALID,
    input  KEY_DOWN,
    input  OVERFLOW,
    output KEY_ACK
  );
endinterface

// File: rtl/hex_keypad_scanner_column_driver.sv
// Column strobe generator for the 4x4 keypad.
//   CLK, RESET_n : system clock, asynchronous active-low reset
//   col          : column strobes, exactly one bit low (1110 -> 1101 -> 1011 -> 0111)
//   col_idx      : index of the column currently strobed
//   sample       : high on the last dwell cycle of each column (rows are read then)
//   sweep_end    : high on the sample cycle of the last column (one sweep complete)
// DWELL must be at least 4 so the row returns have settled through the two-flop
// synchroniser before the sample cycle of each column.
module keypad_column_driver
  import hex_keypad_scanner_pkg::*;
#(
  parameter int DWELL = 48_000
) (
  input  logic                CLK,
  input  logic                RESET_n,
  output logic [KEY_COLS-1:0] col,
  output logic [1:0]          col_idx,
  output logic                sample,
  output logic                sweep_end
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  logic [DW-1:0] dwell_cnt;

  // The strobe ring is registered so the column pins never glitch.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col       <= 4'b1110;
    end else if (dwell_cnt == DWELL_LAST) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
      col       <= {col[KEY_COLS-2:0], col[KEY_COLS-1]};
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  assign sample    = (dwell_cnt == DWELL_LAST);
  assign sweep_end = sample && (col_idx == 2'd3);

endmodule

// File: rtl/hex_keypad_scanner.sv
// Hex keypad scanner: scans a 4x4 keypad, debounces it over whole sweeps and hands one
// key code per press to the IO block.
//   CLK, RESET_n : system clock, asynchronous active-low reset
//   ROW          : row returns, active-low, asynchronous to CLK
//   COL          : column strobes, exactly one bit low
//   key_bus      : master side of the key hand-off bus (code/valid/ack/down/overflow)
//   dbg_state    : current debounce FSM state
// A sweep is classified NONE / ONE(code) / MULTI. The stable counter counts consecutive
// identical sweep results (saturating at DEBOUNCE_SCANS) and the FSM, evaluated once per
// sweep end using the count that includes the sweep just finished, accepts a press or a
// release once that count reaches DEBOUNCE_SCANS.
module hex_keypad_scanner
  import hex_keypad_scanner_pkg::*;
#(
  parameter int CLK_HZ         = 48_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic [KEY_ROWS-1:0]  ROW,
  output logic [KEY_COLS-1:0]  COL,
  hex_keypad_scanner_if.master key_bus,
  output scan_state_t          dbg_state
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int SC_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(DEBOUNCE_SCANS);

  // ---------------------------------------------------------------------------
  // Column scanning
  // ---------------------------------------------------------------------------
  logic [1:0] col_idx;
  logic       sample;
  logic       sweep_end;

  keypad_column_driver #(
    .DWELL (DWELL)
  ) u_col_drv (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .col       (COL),
    .col_idx   (col_idx),
    .sample    (sample),
    .sweep_end (sweep_end)
  );

  // ---------------------------------------------------------------------------
  // Row synchroniser; idle (all ones) out of reset so nothing looks pressed.
  // ---------------------------------------------------------------------------
  logic [KEY_ROWS-1:0] row_meta;
  logic [KEY_ROWS-1:0] row_sync;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= ROW;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep accumulation. acc_lows counts low bits seen so far this sweep,
  // saturating at 2 since only 0 / 1 / many matters.
  // ---------------------------------------------------------------------------
  logic [1:0]            acc_lows;
  logic [KEY_CODE_W-1:0] acc_code;
  logic [2:0]            col_lows;
  logic [2:0]            tot_lows;
  logic [1:0]            new_lows;
  logic [KEY_CODE_W-1:0] new_code;
  sweep_result_t         cur_res;

  always_comb begin
    col_lows = count_low(row_sync);
    tot_lows = {1'b0, acc_lows} + col_lows;
    new_lows = (tot_lows >= 3'd2) ? 2'd2 : tot_lows[1:0];
    new_code = acc_code;
    if (acc_lows == 2'd0 && col_lows == 3'd1) begin
      new_code = {first_low(row_sync), col_idx};
    end
    // Result of the sweep ending this cycle (includes the current sample). The code
    // field is forced to zero unless ONE so results compare cleanly.
    cur_res.kind = SW_NONE;
    cur_res.code = '0;
    case (new_lows)
      2'd0:    cur_res.kind = SW_NONE;
      2'd1: begin
        cur_res.kind = SW_ONE;
        cur_res.code = new_code;
      end
      default: cur_res.kind = SW_MULTI;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      acc_lows <= '0;
      acc_code <= '0;
    end else if (sample) begin
      if (sweep_end) begin
        acc_lows <= '0;
        acc_code <= '0;
      end else begin
        acc_lows <= new_lows;
        acc_code <= new_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stable counter over consecutive identical sweep results.
  // ---------------------------------------------------------------------------
  sweep_result_t prev_res;
  logic [SC_W-1:0] sc_q;
  logic [SC_W-1:0] sc_next;

  always_comb begin
    if (cur_res == prev_res) begin
      sc_next = (sc_q == SC_MAX) ? sc_q : sc_q + SC_W'(1);
    end else begin
      sc_next = SC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      prev_res <= '0;
      sc_q     <= '0;
    end else if (sweep_end) begin
      prev_res <= cur_res;
      sc_q     <= sc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  scan_state_t           state_q;
  scan_state_t           state_d;
  logic [KEY_CODE_W-1:0] cand_q;
  logic [KEY_CODE_W-1:0] cand_d;
  logic                  emit;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ARMED;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    emit    = 1'b0;
    if (sweep_end) begin
      case (state_q)
        ARMED: begin
          if (cur_res.kind == SW_ONE) begin
            state_d = CONFIRM;
            cand_d  = cur_res.code;
          end
        end
        CONFIRM: begin
          if (cur_res.kind == SW_ONE) begin
            if (cur_res.code != cand_q) begin
              // A different single key restarts the confirmation with it.
              cand_d = cur_res.code;
            end else if (sc_next == SC_MAX) begin
              state_d = HELD;
              emit    = 1'b1;
            end
          end else begin
            state_d = ARMED;
          end
        end
        HELD: begin
          // Rollover and extra keys are ignored until a clean release.
          if (cur_res.kind == SW_NONE) state_d = RELEASING;
        end
        RELEASING: begin
          if (cur_res.kind != SW_NONE) begin
            state_d = HELD;
          end else if (sc_next == SC_MAX) begin
            state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Key hand-off. An ack on the same edge as an emit frees the slot first, so the
  // new key loads and OVERFLOW clears.
  // ---------------------------------------------------------------------------
  logic [KEY_CODE_W-1:0] key_code_q;
  logic                  key_valid_q;
  logic                  overflow_q;
  logic                  ack_take;

  assign ack_take = key_bus.KEY_ACK && key_valid_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (emit) begin
      if (!key_valid_q || ack_take) begin
        key_code_q  <= cand_q;
        key_valid_q <= 1'b1;
        overflow_q  <= 1'b0;
      end else begin
        overflow_q  <= 1'b1;
      end
    end else if (ack_take) begin
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end
  end

  assign key_bus.KEY_CODE  = key_code_q;
  assign key_bus.KEY_VALID = key_valid_q;
  assign key_bus.OVERFLOW  = overflow_q;
  assign key_bus.KEY_DOWN  = (state_q == HELD);
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
module tb_hex_keypad_scanner;
  import hex_keypad_scanner_pkg::*;

  localparam int DEB       = 3;
  localparam int SWEEP     = 16;
  localparam int LAT_BOUND = 2 + (DEB + 1) * SWEEP + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  logic [3:0]  ROW;
  logic [3:0]  COL;
  scan_state_t dbg_state;
  logic [15:0] key_mat = '0;

  hex_keypad_scanner_if kb();

  hex_keypad_scanner #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (250),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .ROW       (ROW),
    .COL       (COL),
    .key_bus   (kb),
    .dbg_state (dbg_state)
  );

  // Keypad matrix: a pressed key (r,c) pulls row r low while column c is strobed.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mat[r*4+c] && !COL[c]) ROW[r] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model (sweep-level behaviour)
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  int         m_prev_kind;   // 0 none, 1 one key, 2 several keys
  logic [3:0] m_prev_code;
  int         m_run;         // length of the current run of identical sweeps
  bit         m_down;        // a press has been accepted and not yet released
  bit         m_key_down;
  bit         m_valid;
  bit         m_ovf;
  logic [3:0] m_code;
  logic [3:0] exp_q[$];      // accepted key codes in order

  task automatic model_reset();
    m_prev_kind = 0;
    m_prev_code = '0;
    m_run       = 0;
    m_down      = 1'b0;
    m_key_down  = 1'b0;
    m_valid     = 1'b0;
    m_ovf       = 1'b0;
    m_code      = '0;
  endtask

  task automatic model_sweep(input logic [15:0] keys, input bit ack_at_edge);
    int         n;
    int         kind;
    logic [3:0] code;
    n    = $countones(keys);
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = '0;
    for (int i = 0; i < 16; i++) if (keys[i]) code = 4'(i);
    if (kind == m_prev_kind && (kind != 1 || code == m_prev_code)) m_run++;
    else m_run = 1;
    m_prev_kind = kind;
    m_prev_code = code;
    if (ack_at_edge && m_valid) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
    if (!m_down) begin
      if (kind == 1 && m_run == DEB) begin
        m_down = 1'b1;
        exp_q.push_back(code);
        if (m_valid) m_ovf = 1'b1;
        else begin
          m_code  = code;
          m_valid = 1'b1;
        end
      end
    end else if (kind == 0 && m_run == DEB) begin
      m_down = 1'b0;
    end
    m_key_down = m_down && (kind != 0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: hold one key set for one full sweep, optional ack mid-sweep or on the
  // sweep-end edge. Starts and ends on a falling edge aligned to the sweep boundary.
  // ---------------------------------------------------------------------------
  task automatic do_sweep(input logic [15:0] keys, input bit ack_mid, input bit ack_end);
    logic [3:0] exp_col;
    key_mat = keys;
    for (int i = 0; i < SWEEP; i++) begin
      kb.KEY_ACK = (ack_mid && i == 8) || (ack_end && i == SWEEP - 1);
      @(posedge CLK);
      if (ack_mid && i == 8 && m_valid) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end
      @(negedge CLK);
      exp_col = 4'hF;
      exp_col[((i + 1) / 4) % 4] = 1'b0;
      n_cmp++;
      if (COL !== exp_col) begin
        n_fail++;
        $display("FAIL col_scan t=%0t: got %b expected %b", $time, COL, exp_col);
      end
      if (ack_mid && i == 8) begin
        n_cmp++;
        if (kb.KEY_VALID !== m_valid) begin
          n_fail++;
          $display("FAIL valid_after_ack t=%0t: got %b expected %b", $time, kb.KEY_VALID, m_valid);
        end
      end
    end
    kb.KEY_ACK = 1'b0;
    model_sweep(keys, ack_end);
    n_cmp++;
    if ({kb.KEY_VALID, kb.KEY_CODE, kb.OVERFLOW, kb.KEY_DOWN} !== {m_valid, m_code, m_ovf, m_key_down}) begin
      n_fail++;
      $display("FAIL sweep_outputs t=%0t keys=%h: got valid=%b code=%h ovf=%b down=%b expected valid=%b code=%h ovf=%b down=%b",
               $time, keys, kb.KEY_VALID, kb.KEY_CODE, kb.OVERFLOW, kb.KEY_DOWN, m_valid, m_code, m_ovf, m_key_down);
    end
  endtask

  task automatic release_and_ack();
    do_sweep('0, 1'b0, 1'b0);
    do_sweep('0, 1'b0, 1'b0);
    do_sweep('0, 1'b1, 1'b0);
  endtask

  task automatic press(input int k, input int sweeps);
    logic [15:0] keys;
    keys = '0;
    keys[k] = 1'b1;
    for (int s = 0; s < sweeps; s++) do_sweep(keys, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RESET_n    = 1'b0;
    key_mat    = '0;
    kb.KEY_ACK = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({COL, kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW} !== {4'b1110, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got col=%b code=%h valid=%b down=%b ovf=%b expected 1110/0/0/0/0",
               COL, kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW);
    end
    n_cmp++;
    if (dbg_state !== ARMED) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ARMED);
    end
    RESET_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    for (int s = 0; s < 4; s++) do_sweep('0, 1'b0, 1'b0);
    n_cmp++;
    if (kb.KEY_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: got %b expected 0", kb.KEY_VALID);
    end
  endtask

  task automatic test_clean_press();
    int press_cyc;
    int lat;
    bit seen;
    press_cyc = cyc;
    seen = 1'b0;
    lat = 0;
    for (int s = 0; s < 20; s++) begin
      press(9, 1);
      if (!seen && kb.KEY_VALID) begin
        seen = 1'b1;
        lat  = cyc - press_cyc;
      end
    end
    n_cmp++;
    if (!seen || lat > LAT_BOUND) begin
      n_fail++;
      $display("FAIL press_latency: got seen=%b cycles=%0d expected <= %0d", seen, lat, LAT_BOUND);
    end
    n_cmp++;
    if ({kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW} !== {4'h9, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL clean_press: got code=%h valid=%b down=%b ovf=%b expected 9/1/1/0",
               kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW);
    end
    release_and_ack();
  endtask

  task automatic test_bounce();
    logic [15:0] keys;
    keys = 16'h0020;
    for (int s = 0; s < 6; s++) begin
      do_sweep((s % 2 == 0) ? keys : 16'h0000, 1'b0, 1'b0);
      n_cmp++;
      if (kb.KEY_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_early_emit sweep=%0d: got valid=%b expected 0", s, kb.KEY_VALID);
      end
    end
    press(5, 5);
    n_cmp++;
    if ({kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW} !== {4'h5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bounce_emit: got code=%h valid=%b ovf=%b expected 5/1/0", kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW);
    end
    release_and_ack();
  endtask

  task automatic test_overflow();
    press(3, 3);
    for (int s = 0; s < 3; s++) do_sweep('0, 1'b0, 1'b0);
    press(7, 3);
    n_cmp++;
    if ({kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW} !== {4'h3, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_drop: got code=%h valid=%b ovf=%b expected 3/1/1", kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW);
    end
    release_and_ack();
    n_cmp++;
    if ({kb.KEY_VALID, kb.OVERFLOW} !== 2'b00) begin
      n_fail++;
      $display("FAIL overflow_ack: got valid=%b ovf=%b expected 0/0", kb.KEY_VALID, kb.OVERFLOW);
    end
  endtask

  task automatic test_ack_with_emit();
    logic [15:0] keys;
    press(1, 3);
    for (int s = 0; s < 3; s++) do_sweep('0, 1'b0, 1'b0);
    press(2, 3);
    for (int s = 0; s < 3; s++) do_sweep('0, 1'b0, 1'b0);
    keys = '0;
    keys[12] = 1'b1;
    do_sweep(keys, 1'b0, 1'b0);
    do_sweep(keys, 1'b0, 1'b0);
    do_sweep(keys, 1'b0, 1'b1);
    n_cmp++;
    if ({kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW} !== {4'hC, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_with_emit: got code=%h valid=%b ovf=%b expected C/1/0", kb.KEY_CODE, kb.KEY_VALID, kb.OVERFLOW);
    end
    release_and_ack();
  endtask

  task automatic test_multi_and_reset();
    logic [15:0] keys;
    keys = 16'h8001;
    for (int s = 0; s < 6; s++) do_sweep(keys, 1'b0, 1'b0);
    n_cmp++;
    if ({kb.KEY_VALID, kb.KEY_DOWN} !== 2'b00) begin
      n_fail++;
      $display("FAIL multi_key: got valid=%b down=%b expected 0/0", kb.KEY_VALID, kb.KEY_DOWN);
    end
    do_sweep('0, 1'b0, 1'b0);
    // Leave a key pending, then catch a new press mid-confirmation.
    press(9, 3);
    for (int s = 0; s < 3; s++) do_sweep('0, 1'b0, 1'b0);
    press(6, 2);
    n_cmp++;
    if (dbg_state !== CONFIRM) begin
      n_fail++;
      $display("FAIL confirm_state: got %0d expected %0d", dbg_state, CONFIRM);
    end
    key_mat = 16'h0040;
    repeat (5) @(negedge CLK);
    RESET_n = 1'b0;
    #1;
    n_cmp++;
    if ({COL, kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW} !== {4'b1110, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midscan_reset: got col=%b code=%h valid=%b down=%b ovf=%b expected 1110/0/0/0/0",
               COL, kb.KEY_CODE, kb.KEY_VALID, kb.KEY_DOWN, kb.OVERFLOW);
    end
    n_cmp++;
    if (dbg_state !== ARMED) begin
      n_fail++;
      $display("FAIL midscan_reset_state: got %0d expected %0d", dbg_state, ARMED);
    end
    repeat (2) @(negedge CLK);
    model_reset();
    RESET_n = 1'b1;
    press(6, 2);
    n_cmp++;
    if (kb.KEY_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL held_through_reset_early: got valid=%b expected 0", kb.KEY_VALID);
    end
    press(6, 1);
    n_cmp++;
    if ({kb.KEY_CODE, kb.KEY_VALID} !== {4'h6, 1'b1}) begin
      n_fail++;
      $display("FAIL held_through_reset_emit: got code=%h valid=%b expected 6/1", kb.KEY_CODE, kb.KEY_VALID);
    end
    release_and_ack();
  endtask

  task automatic test_random();
    logic [15:0] keys;
    int pick;
    int a;
    int b;
    int hold;
    for (int blk = 0; blk < 25; blk++) begin
      pick = $urandom_range(0, 9);
      keys = '0;
      a = $urandom_range(0, 15);
      if (pick >= 4) keys[a] = 1'b1;
      if (pick >= 8) begin
        b = (a + $urandom_range(1, 15)) % 16;
        keys[b] = 1'b1;
      end
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        do_sweep(keys, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    kb.KEY_ACK = 1'b0;
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce();
    test_overflow();
    test_ack_with_emit();
    test_multi_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
